// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer: two INTA pulses, vector capture, valid/ready hand-off.
// Optional INT_SYNC_EN macro adds a two-flop synchronizer on INT for an asynchronous controller.
module inta_sequencer #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       INT,
  input  logic       ENABLE,
  input  logic [7:0] DATABUS,
  output logic       INTA,
  output logic [7:0] VECTOR,
  output logic       VECTOR_VALID,
  input  logic       VECTOR_READY,
  output logic       BUSY,
  output logic [7:0] ACK_COUNT
);
  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [2:0] {S_IDLE, S_ACK1, S_GAP, S_ACK2, S_HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          int_eff;

`ifdef INT_SYNC_EN
  logic int_s1, int_s2;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      int_s1 <= 1'b0;
      int_s2 <= 1'b0;
    end else begin
      int_s1 <= INT;
      int_s2 <= int_s1;
    end
  end
  assign int_eff = int_s2;
`else
  assign int_eff = INT;
`endif

  // Once ACK1 starts the sequence runs to HOLD regardless of INT/ENABLE.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state        <= S_IDLE;
      cnt          <= '0;
      INTA         <= 1'b1;
      VECTOR       <= 8'h00;
      VECTOR_VALID <= 1'b0;
      ACK_COUNT    <= 8'h00;
    end else begin
      case (state)
        S_IDLE: if (int_eff && ENABLE) begin
          state <= S_ACK1;
          cnt   <= PULSE_LD;
          INTA  <= 1'b0;
        end
        S_ACK1: if (cnt == CNT_LAST) begin
          state <= S_GAP;
          cnt   <= GAP_LD;
          INTA  <= 1'b1;
        end else cnt <= cnt - CNT_LAST;
        S_GAP: if (cnt == CNT_LAST) begin
          state <= S_ACK2;
          cnt   <= PULSE_LD;
          INTA  <= 1'b0;
        end else cnt <= cnt - CNT_LAST;
        S_ACK2: if (cnt == CNT_LAST) begin
          state        <= S_HOLD;
          INTA         <= 1'b1;
          VECTOR       <= DATABUS;
          VECTOR_VALID <= 1'b1;
        end else cnt <= cnt - CNT_LAST;
        S_HOLD: if (VECTOR_READY) begin
          state        <= S_IDLE;
          VECTOR_VALID <= 1'b0;
          ACK_COUNT    <= ACK_COUNT + 8'd1;
        end
        default: begin
          state <= S_IDLE;
          INTA  <= 1'b1;
        end
      endcase
    end
  end

  assign BUSY = (state != S_IDLE);
endmodule

// File: tb/tb_inta_sequencer.sv
// Scoreboard bench for inta_sequencer: timeline reference model plus directed and random stimulus.
module tb_inta_sequencer;
  localparam int P = 2;
  localparam int G = 2;
  localparam int SEQ_LEN = 2 * P + G;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       INT = 1'b0, ENABLE = 1'b0, VECTOR_READY = 1'b0;
  logic [7:0] DATABUS = 8'h00;
  logic       INTA, VECTOR_VALID, BUSY;
  logic [7:0] VECTOR, ACK_COUNT;

  inta_sequencer #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .CLK(CLK), .RST_N(RST_N), .INT(INT), .ENABLE(ENABLE), .DATABUS(DATABUS),
    .INTA(INTA), .VECTOR(VECTOR), .VECTOR_VALID(VECTOR_VALID),
    .VECTOR_READY(VECTOR_READY), .BUSY(BUSY), .ACK_COUNT(ACK_COUNT)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a sequence is a start cycle plus a fixed timeline of offsets.
  bit         m_started = 0;
  bit         m_inseq = 0, m_hold = 0;
  int         m_cyc = 0, m_start = 0;
  logic [7:0] m_cnt = 8'h00, m_vec = 8'h00;
  bit         m_d1 = 0, m_d2 = 0;
  logic [15:0] sbq[$];   // {expected ACK_COUNT at hand-off, expected VECTOR}
  int         hs = 0;

  always @(posedge CLK) begin
    bit eff;
    m_started = 1;
    if (!RST_N) begin
      m_inseq = 0; m_hold = 0; m_cnt = 8'h00; m_vec = 8'h00;
      m_d1 = 0; m_d2 = 0;
      sbq.delete();
    end else begin
`ifdef INT_SYNC_EN
      eff = m_d2;
`else
      eff = INT;
`endif
      if (m_hold) begin
        if (VECTOR_READY) begin m_hold = 0; m_cnt = m_cnt + 8'd1; end
      end else if (m_inseq) begin
        if (m_cyc - m_start == SEQ_LEN) begin
          m_vec = DATABUS;
          sbq.push_back({m_cnt, DATABUS});
          m_inseq = 0; m_hold = 1;
        end
      end else if (eff && ENABLE) begin
        m_inseq = 1; m_start = m_cyc;
      end
      m_d2 = m_d1; m_d1 = INT;
    end
    m_cyc++;
  end

  // Per-cycle output check against the timeline, and scoreboard pop on hand-off.
  always @(negedge CLK) begin
    int  k;
    bit  low;
    if (m_started) begin
      k   = m_cyc - m_start;
      low = m_inseq && !(k > P && k <= P + G);
      chk("inta", INTA, !low);
      chk("busy", BUSY, m_inseq || m_hold);
      chk("valid", VECTOR_VALID, m_hold);
      chk("ack_count", ACK_COUNT, m_cnt);
      chk("vector_hold", VECTOR, m_vec);
      if (RST_N && VECTOR_VALID) begin
        if (sbq.size() == 0) begin
          chk("sb_nonempty", 0, 1);
        end else begin
          chk("sb_vector", VECTOR, sbq[0][7:0]);
          if (VECTOR_READY) begin
            chk("sb_count", ACK_COUNT, sbq[0][15:8]);
            void'(sbq.pop_front());
            hs++;
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    int base;
    int guard;
    cyc(3);
    chk("rst_inta", INTA, 1);
    chk("rst_vector", VECTOR, 8'h00);
    chk("rst_valid", VECTOR_VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_count", ACK_COUNT, 8'h00);
    RST_N = 1'b1;
    cyc(1);

    // Basic sequence, READY held high.
    INT = 1; ENABLE = 1; DATABUS = 8'h4A; VECTOR_READY = 1;
    cyc(1); INT = 0;
    cyc(12);
    chk("basic_count", ACK_COUNT, 8'd1);
    chk("basic_vector", VECTOR, 8'h4A);

    // ENABLE low blocks the start.
    ENABLE = 0; INT = 1;
    cyc(20);
    chk("en_blocked_busy", BUSY, 0);
    ENABLE = 1;
    cyc(14);
    INT = 0;
    cyc(6);

    // INT drops mid-ACK1.
    INT = 1; DATABUS = 8'h5C;
    cyc(2); INT = 0;
    cyc(12);
    chk("intdrop_vector", VECTOR, 8'h5C);

    // READY held low in HOLD while the bus changes.
    VECTOR_READY = 0; DATABUS = 8'h4A; INT = 1;
    cyc(1); INT = 0;
`ifdef INT_SYNC_EN
    cyc(SEQ_LEN + 2);
`else
    cyc(SEQ_LEN);
`endif
    DATABUS = 8'hFF;
    cyc(10);
    chk("hold_vector", VECTOR, 8'h4A);
    chk("hold_valid", VECTOR_VALID, 1);
    VECTOR_READY = 1;
    cyc(1);
    chk("hold_release", VECTOR_VALID, 0);
    cyc(3);

    // Reset during ACK2.
    INT = 1; DATABUS = 8'h33;
    cyc(1); INT = 0;
`ifdef INT_SYNC_EN
    cyc(6);
`else
    cyc(4);
`endif
    RST_N = 0;
    cyc(1);
    chk("midrst_inta", INTA, 1);
    chk("midrst_valid", VECTOR_VALID, 0);
    chk("midrst_vector", VECTOR, 8'h00);
    chk("midrst_count", ACK_COUNT, 8'h00);
    RST_N = 1;
    cyc(2);

    // 256 back-to-back hand-offs wrap the counter.
    INT = 1; ENABLE = 1; VECTOR_READY = 1;
    base = hs; guard = 0;
    while (hs - base < 256 && guard < 5000) begin
      DATABUS = 8'($urandom);
      cyc(1);
      guard++;
    end
    chk("wrap_done", (hs - base >= 256), 1);
    chk("wrap_count", ACK_COUNT, 8'h00);
    INT = 0;
    cyc(4);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      INT          = ($urandom_range(0, 3) != 0);
      ENABLE       = ($urandom_range(0, 4) != 0);
      VECTOR_READY = ($urandom_range(0, 2) != 0);
      DATABUS      = 8'($urandom);
      RST_N        = ($urandom_range(0, 299) != 0);
      cyc(1);
    end
    RST_N = 1; INT = 0; VECTOR_READY = 1;
    cyc(20);
    chk("final_idle", BUSY, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
